// File: rtl/secded_err_monitor.sv
// SECDED error monitor: classifies decoder words, counts errors,
// runs the alarm FSM and queues error events for a downstream consumer.
module secded_err_monitor #(
  parameter int DATA_W     = 64,
  parameter int CODE_W     = 72,
  parameter int ADDR_W     = 16,
  parameter int CNT_W      = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int SE_THRESH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [CODE_W-1:0] in_data,
  input  logic              in_err_det,
  input  logic              in_single,
  input  logic              in_double,
  input  logic              clr_counts,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic [ADDR_W-1:0] ev_addr,
  output logic              ev_type,
  output logic [DATA_W-1:0] ev_data,
  output logic [CNT_W-1:0]  se_count,
  output logic [CNT_W-1:0]  de_count,
  output logic [CNT_W-1:0]  drop_count,
  output logic [1:0]        alarm
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] THRESH = CNT_W'(SE_THRESH);
  localparam logic [PTR_W:0] DEPTH = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_NORMAL = 2'b00,
    ST_WARN   = 2'b01,
    ST_FATAL  = 2'b10
  } alarm_e;

  logic [ADDR_W-1:0] addr_mem_q [FIFO_DEPTH];
  logic              type_mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] data_mem_q [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0] se_q, se_d;
  logic [CNT_W-1:0] de_q, de_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  alarm_e           alarm_q, alarm_d;

  logic ev_hit, ev_dbl, ev_se, ev_de;
  logic empty, full, pop, push, drop;
  logic [CNT_W-1:0] se_base, de_base, drop_base;

  // Parity columns are not part of the logged payload.
  logic unused_parity;
  assign unused_parity = ^in_data[CODE_W-1:DATA_W];

  always_comb begin
    ev_hit = in_valid & (in_double | in_single | in_err_det);
    // err_det without single is treated as uncorrectable
    ev_dbl = in_double | ~in_single;
    ev_se  = ev_hit & ~ev_dbl;
    ev_de  = ev_hit & ev_dbl;

    empty = (cnt_q == '0);
    full  = (cnt_q == DEPTH);
    pop   = ~empty & ev_ready;
    push  = ev_hit & (~full | pop);
    drop  = ev_hit & full & ~pop;

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (push && !pop) cnt_d = cnt_q + 1'b1;
    if (pop && !push) cnt_d = cnt_q - 1'b1;

    se_base   = clr_counts ? '0 : se_q;
    de_base   = clr_counts ? '0 : de_q;
    drop_base = clr_counts ? '0 : drop_q;

    se_d = se_base;
    if (ev_se && se_base != CNT_MAX) se_d = se_base + 1'b1;
    de_d = de_base;
    if (ev_de && de_base != CNT_MAX) de_d = de_base + 1'b1;
    drop_d = drop_base;
    if (drop && drop_base != CNT_MAX) drop_d = drop_base + 1'b1;

    alarm_d = clr_counts ? ST_NORMAL : alarm_q;
    if (ev_de) begin
      alarm_d = ST_FATAL;
    end else if (alarm_d == ST_NORMAL && se_d >= THRESH) begin
      alarm_d = ST_WARN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      se_q     <= '0;
      de_q     <= '0;
      drop_q   <= '0;
      alarm_q  <= ST_NORMAL;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      se_q     <= se_d;
      de_q     <= de_d;
      drop_q   <= drop_d;
      alarm_q  <= alarm_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      addr_mem_q[wr_ptr_q] <= in_addr;
      type_mem_q[wr_ptr_q] <= ev_dbl;
      data_mem_q[wr_ptr_q] <= in_data[DATA_W-1:0];
    end
  end

  assign ev_valid   = ~empty;
  assign ev_addr    = empty ? '0 : addr_mem_q[rd_ptr_q];
  assign ev_type    = empty ? 1'b0 : type_mem_q[rd_ptr_q];
  assign ev_data    = empty ? '0 : data_mem_q[rd_ptr_q];
  assign se_count   = se_q;
  assign de_count   = de_q;
  assign drop_count = drop_q;
  assign alarm      = alarm_q;

endmodule

// File: tb/tb_secded_err_monitor.sv
// Bench for secded_err_monitor: queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_secded_err_monitor;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_addr;
  logic [71:0] in_data;
  logic        in_err_det;
  logic        in_single;
  logic        in_double;
  logic        clr_counts;
  logic        ev_valid;
  logic        ev_ready;
  logic [15:0] ev_addr;
  logic        ev_type;
  logic [63:0] ev_data;
  logic [15:0] se_count;
  logic [15:0] de_count;
  logic [15:0] drop_count;
  logic [1:0]  alarm;

  secded_err_monitor dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data),
    .in_err_det(in_err_det), .in_single(in_single),
    .in_double(in_double), .clr_counts(clr_counts),
    .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_addr(ev_addr), .ev_type(ev_type), .ev_data(ev_data),
    .se_count(se_count), .de_count(de_count),
    .drop_count(drop_count), .alarm(alarm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  bit run = 1'b0;

  typedef struct {
    logic [15:0] addr;
    logic        typ;
    logic [63:0] data;
  } ev_t;

  ev_t mq[$];
  int m_se, m_de, m_drop, m_alarm;

  function automatic int sat(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  // Reference model: event log as a bounded queue of depth 4.
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_se = 0; m_de = 0; m_drop = 0; m_alarm = 0;
    end else begin
      bit is_ev, is_dbl, do_pop;
      ev_t e;
      is_ev = 0; is_dbl = 0;
      if (in_valid) begin
        if (in_double) begin is_ev = 1; is_dbl = 1; end
        else if (in_single) begin is_ev = 1; is_dbl = 0; end
        else if (in_err_det) begin is_ev = 1; is_dbl = 1; end
      end
      do_pop = (mq.size() > 0) && ev_ready;
      if (clr_counts) begin
        m_se = 0; m_de = 0; m_drop = 0; m_alarm = 0;
      end
      if (do_pop) void'(mq.pop_front());
      if (is_ev) begin
        if (is_dbl) m_de = sat(m_de + 1);
        else m_se = sat(m_se + 1);
        e.addr = in_addr; e.typ = is_dbl; e.data = in_data[63:0];
        if (mq.size() < 4) mq.push_back(e);
        else m_drop = sat(m_drop + 1);
      end
      if (is_ev && is_dbl) m_alarm = 2;
      else if (m_alarm == 0 && m_se >= 8) m_alarm = 1;
    end
  end

  always @(negedge clk) begin
    if (run) begin
      logic [15:0] ea;
      logic        et;
      logic [63:0] ed;
      bit ok;
      ea = '0; et = 1'b0; ed = '0;
      if (mq.size() > 0) begin
        ea = mq[0].addr; et = mq[0].typ; ed = mq[0].data;
      end
      ok = (ev_valid == (mq.size() > 0)) && ev_addr == ea &&
           ev_type == et && ev_data == ed;
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL head t=%0t: got v=%0b a=%h t=%0b d=%h want v=%0b a=%h t=%0b d=%h",
                    $time, ev_valid, ev_addr, ev_type, ev_data,
                    mq.size() > 0, ea, et, ed);
      ok = se_count == 16'(m_se) && de_count == 16'(m_de) &&
           drop_count == 16'(m_drop) && alarm == 2'(m_alarm);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL counts t=%0t: got se=%0d de=%0d dr=%0d al=%0d want se=%0d de=%0d dr=%0d al=%0d",
                    $time, se_count, de_count, drop_count, alarm,
                    m_se, m_de, m_drop, m_alarm);
    end
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 0; in_err_det = 0; in_single = 0; in_double = 0;
    clr_counts = 0; in_addr = '0; in_data = '0;
  endtask

  task automatic send(input logic [15:0] a, input logic [63:0] d,
                      input logic s, input logic dd, input logic det);
    in_valid = 1; in_addr = a; in_data = {8'hFF, d};
    in_single = s; in_double = dd; in_err_det = det;
    tick();
    idle();
  endtask

  function automatic logic [63:0] pat(input logic [15:0] a);
    return {48'hDEAD_0000_0000, a} ^ 64'h0123_4567_0000_0000;
  endfunction

  initial begin
    rst = 1; ev_ready = 0;
    idle();
    tick();
    tick();
    run = 1;
    rst = 0;
    chk("reset_valid", ev_valid, 0);
    chk("reset_alarm", alarm, 0);

    // 1: clean words, and flags without in_valid
    for (int i = 0; i < 5; i++) send(16'(i), 64'(i), 0, 0, 0);
    in_single = 1; in_double = 1; in_err_det = 1;
    tick();
    idle();
    chk("clean_valid", ev_valid, 0);
    chk("clean_se", se_count, 0);
    chk("clean_de", de_count, 0);
    chk("clean_alarm", alarm, 0);

    // 2: single error
    send(16'h0010, 64'hDEADBEEF_CAFECAFE, 1, 0, 1);
    chk("se_valid", ev_valid, 1);
    chk("se_type", ev_type, 0);
    chk("se_addr", ev_addr, 16'h0010);
    chk("se_data", ev_data, 64'hDEADBEEF_CAFECAFE);
    chk("se_count1", se_count, 1);
    tick();
    chk("se_hold", ev_addr, 16'h0010);
    ev_ready = 1;
    tick();
    chk("se_drained", ev_valid, 0);

    // 3: threshold then fatal then clear
    clr_counts = 1;
    tick();
    idle();
    for (int i = 0; i < 7; i++) send(16'h20 + 16'(i), pat(16'(i)), 1, 0, 0);
    chk("thr_7_alarm", alarm, 0);
    send(16'h27, pat(16'h27), 1, 0, 0);
    chk("thr_8_alarm", alarm, 1);
    chk("thr_8_se", se_count, 8);
    send(16'h28, pat(16'h28), 0, 1, 1);
    chk("fatal_alarm", alarm, 2);
    clr_counts = 1;
    tick();
    idle();
    chk("clr_se", se_count, 0);
    chk("clr_de", de_count, 0);
    chk("clr_alarm", alarm, 0);
    tick();

    // 4: overflow with ev_ready low
    ev_ready = 0;
    for (int i = 0; i < 6; i++) send(16'h100 + 16'(i), pat(16'h100 + 16'(i)), 1, 0, 0);
    chk("ovf_drop", drop_count, 2);
    chk("ovf_valid", ev_valid, 1);
    ev_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk("ovf_order", ev_addr, 64'(16'h100 + 16'(i)));
      tick();
    end
    chk("ovf_empty", ev_valid, 0);

    // 5: full FIFO with push and pop together
    ev_ready = 0;
    for (int i = 0; i < 4; i++) send(16'h200 + 16'(i), pat(16'h200 + 16'(i)), 1, 0, 0);
    ev_ready = 1;
    send(16'h204, pat(16'h204), 1, 0, 0);
    ev_ready = 0;
    chk("pp_drop", drop_count, 2);
    ev_ready = 1;
    for (int i = 1; i < 5; i++) begin
      chk("pp_order", ev_addr, 64'(16'h200 + 16'(i)));
      tick();
    end
    chk("pp_empty", ev_valid, 0);

    // 6: corner cases
    clr_counts = 1;
    tick();
    idle();
    ev_ready = 0;
    send(16'h300, pat(16'h300), 0, 0, 1);
    chk("det_type", ev_type, 1);
    chk("det_de", de_count, 1);
    chk("det_alarm", alarm, 2);
    clr_counts = 1;
    send(16'h301, pat(16'h301), 0, 1, 0);
    chk("clrev_de", de_count, 1);
    chk("clrev_alarm", alarm, 2);
    send(16'h302, pat(16'h302), 1, 0, 0);
    chk("rst_pre_valid", ev_valid, 1);
    rst = 1;
    in_valid = 1; in_double = 1; in_addr = 16'h3FF;
    tick();
    rst = 0;
    idle();
    chk("rst_valid", ev_valid, 0);
    chk("rst_de", de_count, 0);
    chk("rst_alarm", alarm, 0);
    tick();
    tick();

    run = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
